// File: rtl/input_pkg.sv
// Shared types and helpers for the direction input conditioner.
// Holds the direction encoding, button bit positions and the fixed
// up > down > left > right priority resolver.
package input_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // Highest-priority held button wins; nothing held gives DIR_NONE.
  function automatic dir_e fixed_prio(input logic [3:0] lvl);
    dir_e d;
    d = DIR_NONE;
    if (lvl[BTN_UP])         d = DIR_UP;
    else if (lvl[BTN_DOWN])  d = DIR_DOWN;
    else if (lvl[BTN_LEFT])  d = DIR_LEFT;
    else if (lvl[BTN_RIGHT]) d = DIR_RIGHT;
    return d;
  endfunction

  // True when the button belonging to direction d is currently held.
  function automatic logic dir_held(input dir_e d, input logic [3:0] lvl);
    logic h;
    h = 1'b0;
    case (d)
      DIR_UP:    h = lvl[BTN_UP];
      DIR_DOWN:  h = lvl[BTN_DOWN];
      DIR_LEFT:  h = lvl[BTN_LEFT];
      DIR_RIGHT: h = lvl[BTN_RIGHT];
      default:   h = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/dir_input_conditioner_debounce_bit.sv
// Single-button synchroniser plus debouncer.
// The raw (already polarity-corrected) input crosses SYNC_STAGES flops,
// then must hold a new value for DEBOUNCE_CYCLES synchronised cycles
// before the stable level follows it. Any return to the stable value
// before that clears the count.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;

  assign s     = sync_q[SYNC_STAGES-1];
  assign level = stable_q;

  // Shift the synchroniser and run the persist counter.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/dir_input_conditioner.sv
// Four-button direction conditioner feeding the sprite renderer.
// Each button is synchronised and debounced, press pulses are derived
// from debounced rising edges, and the held buttons are resolved into
// at most one active direction (one-hot out_*, encoded dir_code).
// Build option: LAST_PRESS_PRIORITY_EN -- the most recently pressed,
// still-held button owns the output instead of fixed priority.
module dir_input_conditioner
  import input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] press_pulse,
  output logic       out_up,
  output logic       out_down,
  output logic       out_left,
  output logic       out_right,
  output logic [2:0] dir_code
);

  logic [3:0] btn_pol;
  logic [3:0] level;
  logic [3:0] rise;

  logic [3:0] prev_level_q, prev_level_d;
  logic [3:0] press_q, press_d;
  dir_e       dir_q, dir_d;
`ifdef LAST_PRESS_PRIORITY_EN
  dir_e       last_q, last_d;
`endif

  assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_pol[gi]),
        .level  (level[gi])
      );
    end
  endgenerate

  assign rise = level & ~prev_level_q;

  // Edge detect and direction resolution for the next cycle.
  always_comb begin
    prev_level_d = level;
    press_d      = rise;
    dir_d        = fixed_prio(level);
`ifdef LAST_PRESS_PRIORITY_EN
    last_d = last_q;
    if (rise != 4'b0000) last_d = fixed_prio(rise);
    if (last_d != DIR_NONE && dir_held(last_d, level)) dir_d = last_d;
`endif
  end

  // Output and history registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_level_q <= '0;
      press_q      <= '0;
      dir_q        <= DIR_NONE;
`ifdef LAST_PRESS_PRIORITY_EN
      last_q       <= DIR_NONE;
`endif
    end else begin
      prev_level_q <= prev_level_d;
      press_q      <= press_d;
      dir_q        <= dir_d;
`ifdef LAST_PRESS_PRIORITY_EN
      last_q       <= last_d;
`endif
    end
  end

  assign btn_level   = level;
  assign press_pulse = press_q;
  assign dir_code    = dir_q;
  assign out_up      = (dir_q == DIR_UP);
  assign out_down    = (dir_q == DIR_DOWN);
  assign out_left    = (dir_q == DIR_LEFT);
  assign out_right   = (dir_q == DIR_RIGHT);

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Directed bench for dir_input_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change and outputs are read 1 time unit
// after each rising edge; "edge k" counts edges after the input change.
module tb_dir_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level, press_pulse;
  logic       out_up, out_down, out_left, out_right;
  logic [2:0] dir_code;
  logic [3:0] outs;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign outs = {out_right, out_left, out_down, out_up};

  dir_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3),
    .BTN_ACTIVE_LOW  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .out_up      (out_up),
    .out_down    (out_down),
    .out_left    (out_left),
    .out_right   (out_right),
    .dir_code    (dir_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pulses;

  initial begin
    // Reset with all buttons pressed: nothing may propagate.
    rst = 1'b0;
    btn_raw = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("rst_level", btn_level, 4'b0000);
      check("rst_outs", {press_pulse, outs, 1'b0, dir_code}, 12'h000);
    end
    rst = 1'b1;
    tick(5);
    check("rel_level_e5", btn_level, 4'b0000);
    tick(1);
    check("rel_level_e6", btn_level, 4'b1111);
    tick(1);
    check("rel_dir_e7", dir_code, 3'd1);
    check("rel_outs_e7", outs, 4'b0001);
    btn_raw = 4'b0000;
    tick(10);
    check("idle_level", btn_level, 4'b0000);
    check("idle_dir", dir_code, 3'd0);

    // Up press and release.
    btn_raw = 4'b0001;
    tick(5);
    check("up_level_e5", btn_level, 4'b0000);
    tick(1);
    check("up_level_e6", btn_level, 4'b0001);
    check("up_pulse_e6", press_pulse, 4'b0000);
    check("up_outs_e6", outs, 4'b0000);
    tick(1);
    check("up_pulse_e7", press_pulse, 4'b0001);
    check("up_outs_e7", outs, 4'b0001);
    check("up_dir_e7", dir_code, 3'd1);
    tick(1);
    check("up_pulse_e8", press_pulse, 4'b0000);
    check("up_hold_e8", outs, 4'b0001);
    tick(3);
    btn_raw = 4'b0000;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (press_pulse != 4'b0000) pulses++;
      if (k == 6) check("uprel_outs_e6", outs, 4'b0001);
      if (k == 7) begin
        check("uprel_outs_e7", outs, 4'b0000);
        check("uprel_dir_e7", dir_code, 3'd0);
      end
    end
    check("uprel_no_pulse", pulses, 0);

    // Glitch of 3 cycles on left must never be accepted.
    btn_raw = 4'b0100;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) btn_raw = 4'b0000;
      tick(1);
      check("glitch", {btn_level, press_pulse, 3'b000, out_left}, 12'h000);
    end

    // Mid-debounce reset discards the partial count.
    btn_raw = 4'b0010;
    tick(4);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);
    check("mrst_level_e5", btn_level, 4'b0000);
    tick(1);
    check("mrst_level_e6", btn_level, 4'b0010);
    tick(1);
    check("mrst_dir_e7", dir_code, 3'd2);
    btn_raw = 4'b0000;
    tick(10);

    // Bounce on right: 1,0,1,0,1 then hold 1.
    pulses = 0;
    btn_raw = 4'b1000; tick(1); if (press_pulse[3]) pulses++;
    btn_raw = 4'b0000; tick(1); if (press_pulse[3]) pulses++;
    btn_raw = 4'b1000; tick(1); if (press_pulse[3]) pulses++;
    btn_raw = 4'b0000; tick(1); if (press_pulse[3]) pulses++;
    btn_raw = 4'b1000;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (press_pulse[3]) pulses++;
      if (k == 6) check("bnc_right_e6", out_right, 1'b0);
      if (k == 7) begin
        check("bnc_right_e7", out_right, 1'b1);
        check("bnc_dir_e7", dir_code, 3'd4);
      end
    end
    check("bnc_one_pulse", pulses, 1);
    btn_raw = 4'b0000;
    tick(10);

    // Up + left together, then release up.
    btn_raw = 4'b0101;
    tick(7);
    check("sim_pulse_e7", press_pulse, 4'b0101);
    check("sim_outs_e7", outs, 4'b0001);
    tick(3);
    btn_raw = 4'b0100;
    tick(6);
    check("sim_rel_e6", outs, 4'b0001);
    tick(1);
    check("sim_rel_e7", outs, 4'b0100);
    check("sim_rel_dir", dir_code, 3'd3);
    btn_raw = 4'b0000;
    tick(10);

    // Hold up, then add right 20 cycles later, then release right.
    btn_raw = 4'b0001;
    tick(7);
    check("lp_up", outs, 4'b0001);
    tick(13);
    btn_raw = 4'b1001;
    tick(6);
    check("lp_add_e6", outs, 4'b0001);
    tick(1);
`ifdef LAST_PRESS_PRIORITY_EN
    check("lp_add_e7", outs, 4'b1000);
    check("lp_add_dir", dir_code, 3'd4);
`else
    check("lp_add_e7", outs, 4'b0001);
    check("lp_add_dir", dir_code, 3'd1);
`endif
    tick(5);
    btn_raw = 4'b0001;
    tick(7);
    check("lp_relr_e7", outs, 4'b0001);
    check("lp_relr_dir", dir_code, 3'd1);
    btn_raw = 4'b0000;
    tick(8);
    check("final_idle", {btn_level, outs}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dir_input_conditioner.md
Name: dir_input_conditioner

Overview:
- Sits directly upstream of the sprite/movement renderer and drives its in_up/in_down/in_left/in_right inputs.
- Takes four raw, asynchronous board push-buttons and synchronises each one, then debounces each one.
- Resolves the debounced buttons into at most one active direction, because the renderer must never see two directions at once.
- Also provides debounced levels, press pulses and an encoded direction for menu/game-state logic.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the per-button synchroniser; legal range is 2 or more.
- DEBOUNCE_CYCLES, 1000000: synchronised-input cycles a change must persist before it is accepted (10 ms at 100 MHz); minimum 2.
- CNT_WIDTH, 20: debounce counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 0: when 1, btn_raw is inverted before the synchroniser.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low.
- btn_raw, input, 4: asynchronous buttons; [0]=up, [1]=down, [2]=left, [3]=right.
- btn_level, output, 4: debounced, active-high levels, same bit order as btn_raw.
- press_pulse, output, 4: one-cycle pulse on each 0->1 transition of btn_level.
- out_up, output, 1: resolved direction up (to the renderer).
- out_down, output, 1: resolved direction down.
- out_left, output, 1: resolved direction left.
- out_right, output, 1: resolved direction right.
- dir_code, output, 3: encoded resolved direction using dir_e (NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4).

Behaviour:
- Reset (rst=0 at a clk edge): all synchroniser flops go to 0 (inactive, after polarity correction), as do all debounce counters and stable levels. btn_level=0, press_pulse=0, out_*=0, dir_code=NONE.
- Reset applied mid-debounce discards the partial count.
- Synchroniser: polarity-corrected btn_raw passes through SYNC_STAGES flops; s_i is the last stage.
- Debounce, per bit i, evaluated every clk edge:
  - If s_i == stable_i: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: stable_i <= s_i and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
- Any return to the stable value before commit clears the count. Glitches shorter than DEBOUNCE_CYCLES synchronised cycles therefore never reach btn_level.
- btn_level = stable.
- Latency: a raw change held constant appears on btn_level exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after it is first sampled. press_pulse and out_*/dir_code are registered and follow one edge after btn_level.
- press_pulse[i] = btn_level[i] & ~btn_level_d[i], registered, so it is high for exactly one cycle per debounced press. Releases produce no pulse.
- Direction resolution, registered and evaluated every cycle, uses fixed priority up > down > left > right among held btn_level bits.
- out_* is one-hot or all-zero and never has more than one bit set. dir_code matches out_*.
- No buttons held: out_*=0 and dir_code=NONE on the following edge.
- Opposing buttons held together (e.g. up+down): the priority winner is output and the loser is ignored.
- Counters saturate at no value other than DEBOUNCE_CYCLES-1, so they never wrap.

Optional Feature:
- Macro: LAST_PRESS_PRIORITY_EN.
- Defined:
  - A 3-bit last-press register records the direction whose press_pulse fired most recently.
  - Several pulses in the same cycle are resolved by fixed priority.
  - While that button remains held it owns the output, overriding fixed priority.
  - When it is released, the output falls back to fixed priority among the buttons still held.
  - The register resets to NONE.
- Undefined: pure fixed priority only; the last-press register is not generated.

Decomposition:
- Package input_pkg holds:
  - typedef enum logic [2:0] dir_e {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - localparams BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3;
  - function fixed_prio(logic [3:0]) returning dir_e.
- Sub-module debounce_bit (parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_WIDTH) contains the synchroniser, counter and stable flop. It is instantiated 4 times via generate.
- The top level contains the edge detect, priority resolution and optional last-press logic.

Test Plan (all with DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset check: hold rst=0 for 3 cycles with btn_raw=4'b1111, then release -> all outputs stay 0 during reset; after release, btn_level=4'b1111 exactly 6 edges later.
- Up press: btn_raw[0] 0->1 and held -> btn_level[0] rises at edge 6; press_pulse[0]=1 for one cycle and out_up=1/dir_code=UP at edge 7; release -> out_up=0 at edge 7 after release; no release pulse.
- Glitch reject: btn_raw[2] high for 3 cycles, then low -> btn_level, press_pulse and out_left all remain 0 throughout.
- Bounce: toggle btn_raw[3] 1,0,1,0,1 on successive cycles, then hold 1 -> exactly one press_pulse[3]; out_right rises 7 edges after the final rising sample.
- Simultaneous: btn_raw=4'b0101 (up+left) in the same cycle -> out_up=1, out_left=0; then release up -> out_left=1 at the next resolution edge.
- LAST_PRESS_PRIORITY_EN: hold up, then 20 cycles later also press right -> out_right=1, out_up=0; release right -> out_up=1. Without the macro, out_up stays 1 throughout.
